// File: rtl/slos_rx_pkg.sv
// Shared types for the SLOS receive sequencer: state encoding and counter widths.
package slos_rx_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitSlos1 = 3'd1,
        StRestart   = 3'd2,
        StWaitSlos2 = 3'd3,
        StDone      = 3'd4,
        StFail      = 3'd5
    } slos_state_e;

endpackage

// File: rtl/slos_rx_timer.sv
// Clearable saturating up-counter; hit flags the edge on which the count reaches LIMIT.
module slos_rx_timer #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [W-1:0] count_q;

    assign hit = inc && (count_q == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != W'(LIMIT))) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/slos_rx_ctrl.sv
// PRBS11 SLOS receive sequencer for lane training (SLOS1 then SLOS2 phase).
// Optional SLOS_RX_DEBUG_EN adds dbg_state and dbg_brk_cnt outputs.
module slos_rx_ctrl
    import slos_rx_pkg::*;
#(
    parameter int unsigned REQ_SLOS    = 2,
    parameter int unsigned SLOS_LEN    = 2048,
    parameter int unsigned GAP_MARGIN  = 16,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       slos_rec,
`ifdef SLOS_RX_DEBUG_EN
    output logic [2:0] dbg_state,
    output logic [7:0] dbg_brk_cnt,
`endif
    output logic       prbs_enable,
    output logic       prbs_slos1_slos2,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam int unsigned GAP_LIM = SLOS_LEN + GAP_MARGIN;
    localparam int unsigned GAP_W   = $clog2(GAP_LIM + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC);

    slos_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             in_wait, gap_hit, tmo_hit;

    assign in_wait = (state_q == StWaitSlos1) || (state_q == StWaitSlos2);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Gap only runs once the first pulse has arrived; a break also restarts it.
    slos_rx_timer #(
        .LIMIT (GAP_LIM),
        .W     (GAP_W)
    ) u_gap (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_wait || slos_rec || abort || gap_hit),
        .inc   (in_wait && (cnt_q != '0) && !slos_rec),
        .hit   (gap_hit)
    );

    slos_rx_timer #(
        .LIMIT (TIMEOUT_CYC - 1),
        .W     (TMO_W)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_wait || abort),
        .inc   (in_wait),
        .hit   (tmo_hit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StFail: begin
                    if (start) begin
                        state_d = StWaitSlos1;
                        cnt_d   = '0;
                    end
                end
                StWaitSlos1, StWaitSlos2: begin
                    // A completing pulse beats a coincident timeout.
                    if (slos_rec && (cnt_inc == CNT_W'(REQ_SLOS))) begin
                        state_d = (state_q == StWaitSlos1) ? StRestart : StDone;
                        cnt_d   = '0;
                    end else if (tmo_hit) begin
                        state_d = StFail;
                        cnt_d   = '0;
                    end else if (slos_rec) begin
                        cnt_d = cnt_inc;
                    end else if (gap_hit) begin
                        cnt_d = '0;
                    end
                end
                StRestart: begin
                    state_d = StWaitSlos2;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            prbs_enable      <= 1'b0;
            prbs_slos1_slos2 <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fail             <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            prbs_enable      <= (state_d == StWaitSlos1) || (state_d == StWaitSlos2);
            prbs_slos1_slos2 <= (state_d == StRestart) || (state_d == StWaitSlos2) ||
                                (state_d == StDone);
            busy             <= (state_d == StWaitSlos1) || (state_d == StRestart) ||
                                (state_d == StWaitSlos2);
            // done rises one cycle after DONE is entered and drops as it is left.
            done             <= (state_d == StDone) && (state_q == StDone);
            fail             <= (state_d == StFail);
        end
    end

`ifdef SLOS_RX_DEBUG_EN
    logic [7:0] brk_cnt_q;
    logic       brk, start_acc;

    assign brk       = in_wait && gap_hit && !tmo_hit && !abort;
    assign start_acc = start && ((state_q == StIdle) || (state_q == StDone) ||
                                 (state_q == StFail));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_cnt_q <= '0;
        end else if (abort || start_acc) begin
            brk_cnt_q <= '0;
        end else if (brk && (brk_cnt_q != 8'hff)) begin
            brk_cnt_q <= brk_cnt_q + 8'd1;
        end
    end

    assign dbg_state   = state_q;
    assign dbg_brk_cnt = brk_cnt_q;
`endif

endmodule

// File: tb/tb_slos_rx_ctrl.sv
// Directed bench for slos_rx_ctrl with REQ_SLOS=2, SLOS_LEN=16, GAP_MARGIN=4, TIMEOUT_CYC=200.
module tb_slos_rx_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic slos_rec = 1'b0;
    logic prbs_enable, prbs_slos1_slos2, busy, done, fail;
`ifdef SLOS_RX_DEBUG_EN
    logic [2:0] dbg_state;
    logic [7:0] dbg_brk_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    slos_rx_ctrl #(
        .REQ_SLOS    (2),
        .SLOS_LEN    (16),
        .GAP_MARGIN  (4),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .slos_rec         (slos_rec),
`ifdef SLOS_RX_DEBUG_EN
        .dbg_state        (dbg_state),
        .dbg_brk_cnt      (dbg_brk_cnt),
`endif
        .prbs_enable      (prbs_enable),
        .prbs_slos1_slos2 (prbs_slos1_slos2),
        .busy             (busy),
        .done             (done),
        .fail             (fail)
    );

    // Output vector order: {prbs_enable, prbs_slos1_slos2, busy, done, fail}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_W1    = 5'b10100;
    localparam logic [4:0] O_RST   = 5'b01100;
    localparam logic [4:0] O_W2    = 5'b11100;
    localparam logic [4:0] O_DONE0 = 5'b01000;
    localparam logic [4:0] O_DONE1 = 5'b01010;
    localparam logic [4:0] O_FAIL  = 5'b00001;

    typedef struct packed {
        logic       s;
        logic       a;
        logic       r;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs [15];
    int         pulses [$];
    int         bnd [$];
    logic [4:0] exq [$];

    function automatic logic [4:0] outs();
        return {prbs_enable, prbs_slos1_slos2, busy, done, fail};
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic a, input logic r);
        start    = s;
        abort    = a;
        slos_rec = r;
        @(posedge clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        slos_rec = 1'b0;
    endtask

    // Drives cycles c0..c0+n-1 (start in cycle 0 if do_start), pulses from the queue, and
    // checks each following cycle against the piecewise-constant expectation bnd/exq.
    task automatic run_phases(input string name, input int c0, input int n, input bit do_start);
        for (int c = c0; c < c0 + n; c++) begin
            logic r;
            int   idx;
            r = 1'b0;
            foreach (pulses[k]) if (pulses[k] == c) r = 1'b1;
            tick(do_start && (c == 0), 1'b0, r);
            idx = 0;
            foreach (bnd[k]) if (c + 1 >= bnd[k]) idx = k + 1;
            chk(name, c + 1, 32'(outs()), 32'(exq[idx]));
        end
    endtask

    initial begin
        // start, abort, slos_rec, expected outputs after the edge
        vecs[0]  = 8'b000_00000;
        vecs[1]  = 8'b100_10100;
        vecs[2]  = 8'b100_10100;  // start while busy ignored
        vecs[3]  = 8'b001_10100;
        vecs[4]  = 8'b100_10100;  // must not clear cnt
        vecs[5]  = 8'b001_01100;  // second pulse -> RESTART
        vecs[6]  = 8'b000_11100;
        vecs[7]  = 8'b001_11100;
        vecs[8]  = 8'b001_01000;  // DONE entered, done lags one cycle
        vecs[9]  = 8'b000_01010;
        vecs[10] = 8'b000_01010;
        vecs[11] = 8'b110_00000;  // abort beats start
        vecs[12] = 8'b100_10100;
        vecs[13] = 8'b010_00000;
        vecs[14] = 8'b001_00000;  // slos_rec ignored in IDLE

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 0, 32'(outs()), 32'(O_IDLE));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].s, vecs[i].a, vecs[i].r);
            chk("vec", i, 32'(outs()), 32'(vecs[i].exp));
        end

        // Full two-phase handshake with exact latencies
        pulses = '{30, 46, 80, 96};
        bnd    = '{47, 48, 97, 98};
        exq    = '{O_W1, O_RST, O_W2, O_DONE0, O_DONE1};
        run_phases("handshake", 0, 100, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        chk("abort_done", 0, 32'(outs()), 32'(O_IDLE));

        // 21-cycle spacing breaks the run; 20-cycle spacing completes it
        pulses = '{5, 26, 47, 68, 88};
        bnd    = '{89, 90};
        exq    = '{O_W1, O_RST, O_W2};
        run_phases("gap", 0, 88, 1'b1);
`ifdef SLOS_RX_DEBUG_EN
        chk("dbg_brk_cnt", 88, 32'(dbg_brk_cnt), 32'd3);
        chk("dbg_state", 88, 32'(dbg_state), 32'd1);
`endif
        run_phases("gap", 88, 7, 1'b0);
        tick(1'b0, 1'b1, 1'b0);

        // Timeout with no pulses, then restart straight out of FAIL
        pulses = {};
        bnd    = '{200};
        exq    = '{O_W1, O_FAIL};
        run_phases("timeout", 0, 203, 1'b1);
        run_phases("restart_fail", 0, 203, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("abort_start_fail", 0, 32'(outs()), 32'(O_IDLE));

        // Final pulse on the timeout edge: success wins
        pulses = '{180, 199};
        bnd    = '{200, 201};
        exq    = '{O_W1, O_RST, O_W2};
        run_phases("tmo_vs_pulse", 0, 203, 1'b1);

        // Asynchronous reset while in WAIT_SLOS2
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 0, 32'(outs()), 32'(O_IDLE));
        #2;
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        chk("post_reset_idle", 0, 32'(outs()), 32'(O_IDLE));
        tick(1'b1, 1'b0, 1'b0);
        chk("post_reset_start", 0, 32'(outs()), 32'(O_W1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
